// File: rtl/control_unit_fsm_if.sv
// Instruction/ALU/write-back bundle of the multi-cycle control unit.
// slave is the control unit; master is the instruction source/ALU side.
interface control_unit_fsm_if #(
    parameter int OPCODE_W = 3,
    parameter int CNT_W    = 16
);
    logic                instr_valid;
    logic [OPCODE_W-1:0] instr_opcode;
    logic                instr_ready;
    logic [OPCODE_W-1:0] alu_sel;
    logic                alu_start;
    logic                alu_done;
    logic                reg_we;
    logic                flag_we;
    logic                pc_inc;
    logic                err_illegal;
    logic                err_timeout;
    logic [CNT_W-1:0]    retired_cnt;

    modport master (
        output instr_valid, instr_opcode, alu_done,
        input  instr_ready, alu_sel, alu_start, reg_we, flag_we,
        input  pc_inc, err_illegal, err_timeout, retired_cnt
    );

    modport slave (
        input  instr_valid, instr_opcode, alu_done,
        output instr_ready, alu_sel, alu_start, reg_we, flag_we,
        output pc_inc, err_illegal, err_timeout, retired_cnt
    );
endinterface

// File: rtl/control_unit_fsm.sv
// Multi-cycle control unit: DECODE/EXEC/WAIT/WB sequencing,
// multi-cycle ALU handshake with timeout, write-back steering.
module control_unit_fsm #(
    parameter int                      OPCODE_W = 3,
    parameter int                      NUM_OPS  = 8,
    parameter logic [2**OPCODE_W-1:0]  MC_MASK  = 8'b0110_0000,
    parameter int                      CMP_OP   = 7,
    parameter int                      TIMEOUT  = 16,
    parameter int                      CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    control_unit_fsm_if.slave    bus
);
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]      L_TO  = WCW'(TIMEOUT);
    localparam logic [OPCODE_W-1:0] L_CMP = OPCODE_W'(CMP_OP);
    localparam logic [OPCODE_W:0]   L_NUM = (OPCODE_W+1)'(NUM_OPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_WB,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [OPCODE_W-1:0] r_alu_sel;
    logic [WCW-1:0]      r_wait;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_in_rst;
    logic                r_tmo;
    logic                w_accept;
    logic                w_illegal;
    logic                w_mc;
    logic                w_is_cmp;

    // Latched opcode doubles as the ALU select; it is taken on accept.
    assign w_illegal = ({1'b0, r_alu_sel} >= L_NUM);
    assign w_mc      = MC_MASK[r_alu_sel];
    assign w_is_cmp  = (r_alu_sel == L_CMP);
    assign w_accept  = (r_state == S_IDLE) && !r_in_rst
                     && bus.instr_valid;

    assign bus.alu_sel     = r_alu_sel;
    assign bus.retired_cnt = r_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered view of reset so ready stays low without an input path.
    always_ff @(posedge clk) begin
        r_in_rst <= rst;
    end

    // Next state and state-decoded strobes.
    always_comb begin
        w_next          = r_state;
        bus.instr_ready = 1'b0;
        bus.alu_start   = 1'b0;
        bus.reg_we      = 1'b0;
        bus.flag_we     = 1'b0;
        bus.pc_inc      = 1'b0;
        bus.err_illegal = 1'b0;
        bus.err_timeout = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                bus.instr_ready = !r_in_rst;
                if (w_accept) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_illegal ? S_ERR : S_EXEC;
            end
            S_EXEC: begin
                if (w_mc) begin
                    bus.alu_start = 1'b1;
                    w_next        = S_WAIT;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WAIT: begin
                if (bus.alu_done) begin
                    w_next = S_WB;
                end else if (r_wait == L_TO) begin
                    w_next = S_ERR;
                end
            end
            S_WB: begin
                bus.pc_inc  = 1'b1;
                bus.reg_we  = !w_is_cmp;
                bus.flag_we = w_is_cmp;
                w_next      = S_IDLE;
            end
            S_ERR: begin
                bus.pc_inc      = 1'b1;
                bus.err_illegal = !r_tmo;
                bus.err_timeout = r_tmo;
                w_next          = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Opcode latch and error cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_sel <= '0;
            r_tmo     <= 1'b0;
        end else if (w_accept) begin
            r_alu_sel <= bus.instr_opcode;
            r_tmo     <= 1'b0;
        end else if (r_state == S_WAIT && w_next == S_ERR) begin
            r_tmo <= 1'b1;
        end
    end

    // WAIT cycle counter: 1 on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (r_state == S_EXEC) begin
            r_wait <= WCW'(1);
        end else if (r_state == S_WAIT) begin
            r_wait <= r_wait + WCW'(1);
        end else begin
            r_wait <= '0;
        end
    end

    // Retired-instruction counter, bumped once per WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_WB) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: default instance plus a
// NUM_OPS=6 instance for the illegal-opcode path.
module tb_control_unit_fsm;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    control_unit_fsm_if #(.OPCODE_W(3), .CNT_W(16)) bus ();
    control_unit_fsm_if #(.OPCODE_W(3), .CNT_W(16)) bus6 ();

    control_unit_fsm u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    control_unit_fsm #(.NUM_OPS(6)) u_dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    // {ready, start, reg_we, flag_we, pc_inc, ill, tmo}
    localparam logic [6:0] NONE    = 7'b0000000;
    localparam logic [6:0] RDY     = 7'b1000000;
    localparam logic [6:0] START   = 7'b0100000;
    localparam logic [6:0] WB_REG  = 7'b0010100;
    localparam logic [6:0] WB_FLG  = 7'b0001100;
    localparam logic [6:0] ERR_TMO = 7'b0000101;
    localparam logic [6:0] ERR_ILL = 7'b0000110;

    logic [6:0] w_s;
    logic [6:0] w_s6;

    assign w_s  = {bus.instr_ready, bus.alu_start, bus.reg_we,
                   bus.flag_we, bus.pc_inc, bus.err_illegal,
                   bus.err_timeout};
    assign w_s6 = {bus6.instr_ready, bus6.alu_start, bus6.reg_we,
                   bus6.flag_we, bus6.pc_inc, bus6.err_illegal,
                   bus6.err_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present opcode at the current (IDLE) negedge; returns at E0+1.
    task automatic issue(input bit use6, input logic [2:0] op);
        if (use6) begin
            bus6.instr_valid  = 1'b1;
            bus6.instr_opcode = op;
        end else begin
            bus.instr_valid  = 1'b1;
            bus.instr_opcode = op;
        end
        @(negedge clk);
        bus.instr_valid   = 1'b0;
        bus6.instr_valid  = 1'b0;
        bus.instr_opcode  = ~op;
        bus6.instr_opcode = ~op;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.instr_valid   = 1'b0;
        bus.instr_opcode  = 3'd0;
        bus.alu_done      = 1'b0;
        bus6.instr_valid  = 1'b0;
        bus6.instr_opcode = 3'd0;
        bus6.alu_done     = 1'b0;

        // Reset: two cycles with rst high.
        @(negedge clk);
        chk("rst1_strobes", 32'(w_s), 32'(NONE));
        chk("rst1_cnt", 32'(bus.retired_cnt), 32'd0);
        chk("rst1_sel", 32'(bus.alu_sel), 32'd0);
        @(negedge clk);
        chk("rst2_strobes", 32'(w_s), 32'(NONE));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(w_s), 32'(RDY));
        chk("post_rst_cnt", 32'(bus.retired_cnt), 32'd0);

        // ADD: WB at E0+3, ready at E0+4.
        issue(1'b0, 3'd0);
        chk("add_e1", 32'(w_s), 32'(NONE));
        chk("add_e1_sel", 32'(bus.alu_sel), 32'd0);
        @(negedge clk);
        chk("add_e2", 32'(w_s), 32'(NONE));
        @(negedge clk);
        chk("add_e3", 32'(w_s), 32'(WB_REG));
        @(negedge clk);
        chk("add_e4", 32'(w_s), 32'(RDY));
        chk("add_cnt", 32'(bus.retired_cnt), 32'd1);

        // MUL: alu_done during EXEC ignored, real done on 4th WAIT cycle.
        issue(1'b0, 3'd5);
        chk("mul_e1", 32'(w_s), 32'(NONE));
        chk("mul_e1_sel", 32'(bus.alu_sel), 32'd5);
        @(negedge clk);
        chk("mul_e2", 32'(w_s), 32'(START));
        bus.alu_done = 1'b1;
        @(negedge clk);
        bus.alu_done = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            if (k > 3) @(negedge clk);
            chk($sformatf("mul_wait_e%0d", k), 32'(w_s), 32'(NONE));
            chk($sformatf("mul_sel_e%0d", k), 32'(bus.alu_sel), 32'd5);
        end
        bus.alu_done = 1'b1;
        @(negedge clk);
        bus.alu_done = 1'b0;
        chk("mul_e7", 32'(w_s), 32'(WB_REG));
        @(negedge clk);
        chk("mul_e8", 32'(w_s), 32'(RDY));
        chk("mul_cnt", 32'(bus.retired_cnt), 32'd2);

        // CMP: flag write only, select held.
        issue(1'b0, 3'd7);
        chk("cmp_e1_sel", 32'(bus.alu_sel), 32'd7);
        @(negedge clk);
        chk("cmp_e2", 32'(w_s), 32'(NONE));
        chk("cmp_e2_sel", 32'(bus.alu_sel), 32'd7);
        @(negedge clk);
        chk("cmp_e3", 32'(w_s), 32'(WB_FLG));
        chk("cmp_e3_sel", 32'(bus.alu_sel), 32'd7);
        @(negedge clk);
        chk("cmp_e4", 32'(w_s), 32'(RDY));
        chk("cmp_cnt", 32'(bus.retired_cnt), 32'd3);

        // DIV without done: 16 WAIT cycles then timeout.
        issue(1'b0, 3'd6);
        chk("div_e1", 32'(w_s), 32'(NONE));
        @(negedge clk);
        chk("div_e2", 32'(w_s), 32'(START));
        for (int k = 3; k <= 18; k++) begin
            @(negedge clk);
            chk($sformatf("div_wait_e%0d", k), 32'(w_s), 32'(NONE));
        end
        @(negedge clk);
        chk("div_e19", 32'(w_s), 32'(ERR_TMO));
        @(negedge clk);
        chk("div_e20", 32'(w_s), 32'(RDY));
        chk("div_cnt", 32'(bus.retired_cnt), 32'd3);

        // Reset during WAIT, late alu_done must not retire anything.
        issue(1'b0, 3'd6);
        @(negedge clk);
        chk("rw_e2", 32'(w_s), 32'(START));
        @(negedge clk);
        @(negedge clk);
        chk("rw_e4", 32'(w_s), 32'(NONE));
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.alu_done = 1'b1;
        chk("rw_in_rst", 32'(w_s), 32'(NONE));
        @(negedge clk);
        bus.alu_done = 1'b0;
        chk("rw_after", 32'(w_s), 32'(RDY));
        chk("rw_cnt", 32'(bus.retired_cnt), 32'd0);
        @(negedge clk);
        chk("rw_after2", 32'(w_s), 32'(RDY));

        // Illegal opcode on the NUM_OPS=6 instance.
        chk("ill_ready", 32'(w_s6), 32'(RDY));
        issue(1'b1, 3'd6);
        chk("ill_e1", 32'(w_s6), 32'(NONE));
        chk("ill_e1_sel", 32'(bus6.alu_sel), 32'd6);
        @(negedge clk);
        chk("ill_e2", 32'(w_s6), 32'(ERR_ILL));
        @(negedge clk);
        chk("ill_e3", 32'(w_s6), 32'(RDY));
        chk("ill_cnt", 32'(bus6.retired_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
